// File: rtl/ula_multiciclo_pkg.sv
// Shared definitions for the multi-cycle ALU: opcode constants and FSM states.
// Optional multiplier is enabled with the ULA_MUL_EN macro (see ula_multiciclo).
package ula_pkg;

    localparam logic [2:0] ULA_AND = 3'b000;
    localparam logic [2:0] ULA_OR  = 3'b001;
    localparam logic [2:0] ULA_ADD = 3'b010;
    localparam logic [2:0] ULA_SUB = 3'b011;
    localparam logic [2:0] ULA_SLT = 3'b100;
    localparam logic [2:0] ULA_MUL = 3'b101;
    localparam logic [2:0] ULA_SLL = 3'b110;
    localparam logic [2:0] ULA_SRL = 3'b111;

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        EXECUTA   = 2'd1,
        RESULTADO = 2'd2
    } estado_ula_t;

endpackage

// File: rtl/ula_multiciclo_if.sv
// Operand/result handshake bundle between the datapath (master) and the ALU (slave).
interface ula_multiciclo_if #(
    parameter int LARGURA = 8
) ();

    logic               valido_entrada;
    logic               pronto_entrada;
    logic [LARGURA-1:0] entrada1;
    logic [LARGURA-1:0] entrada2;
    logic [2:0]         sinal_ula;
    logic               valido_saida;
    logic               pronto_saida;
    logic [LARGURA-1:0] saida_ula;
    logic               zero;
    logic               estouro;

    modport master (
        output valido_entrada, entrada1, entrada2, sinal_ula, pronto_saida,
        input  pronto_entrada, valido_saida, saida_ula, zero, estouro
    );

    modport slave (
        input  valido_entrada, entrada1, entrada2, sinal_ula, pronto_saida,
        output pronto_entrada, valido_saida, saida_ula, zero, estouro
    );

endinterface

// File: rtl/ula_multiciclo_multiplicador.sv
// Iterative shift-add multiplier: one partial-product step per cycle,
// LARGURA steps, fim_o pulses for one cycle after the last step.
module ula_multiplicador #(
    parameter int LARGURA = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   inicio_i,
    input  logic [LARGURA-1:0]     a_i,
    input  logic [LARGURA-1:0]     b_i,
    output logic                   fim_o,
    output logic [2*LARGURA-1:0]   produto_o
);

    localparam int CW = $clog2(LARGURA);

    logic [2*LARGURA-1:0] multiplicando_q, multiplicando_d;
    logic [2*LARGURA-1:0] produto_q, produto_d;
    logic [LARGURA-1:0]   multiplicador_q, multiplicador_d;
    logic [CW-1:0]        contador_q, contador_d;
    logic                 ocupado_q, ocupado_d;
    logic                 fim_q, fim_d;

    // Load operands on inicio, then add/shift once per cycle until the counter wraps
    always_comb begin
        multiplicando_d = multiplicando_q;
        produto_d       = produto_q;
        multiplicador_d = multiplicador_q;
        contador_d      = contador_q;
        ocupado_d       = ocupado_q;
        fim_d           = 1'b0;
        if (inicio_i) begin
            multiplicando_d = {{LARGURA{1'b0}}, a_i};
            multiplicador_d = b_i;
            produto_d       = '0;
            contador_d      = '0;
            ocupado_d       = 1'b1;
        end else if (ocupado_q) begin
            if (multiplicador_q[0]) begin
                produto_d = produto_q + multiplicando_q;
            end
            multiplicando_d = multiplicando_q << 1;
            multiplicador_d = multiplicador_q >> 1;
            if (contador_q == CW'(LARGURA - 1)) begin
                contador_d = '0;
                ocupado_d  = 1'b0;
                fim_d      = 1'b1;
            end else begin
                contador_d = contador_q + 1'b1;
            end
        end
    end

    // Multiplier state registers; reset discards any partial product
    always_ff @(posedge clock) begin
        if (reset) begin
            multiplicando_q <= '0;
            produto_q       <= '0;
            multiplicador_q <= '0;
            contador_q      <= '0;
            ocupado_q       <= 1'b0;
            fim_q           <= 1'b0;
        end else begin
            multiplicando_q <= multiplicando_d;
            produto_q       <= produto_d;
            multiplicador_q <= multiplicador_d;
            contador_q      <= contador_d;
            ocupado_q       <= ocupado_d;
            fim_q           <= fim_d;
        end
    end

    assign fim_o     = fim_q;
    assign produto_o = produto_q;

endmodule

// File: rtl/ula_multiciclo.sv
// Multi-cycle ALU with valid/ready handshake and registered result.
// Define ULA_MUL_EN to compile in the iterative multiplier (op 101);
// otherwise op 101 completes in one cycle with a zero result.
module ula_multiciclo
    import ula_pkg::*;
#(
    parameter int LARGURA = 8
) (
    input  logic              clock,
    input  logic              reset,
    ula_multiciclo_if.slave   bus
);

    localparam int SW = $clog2(LARGURA);
    localparam int M  = LARGURA - 1;

    estado_ula_t          estado_q, estado_d;
    logic [LARGURA-1:0]   resultado_q, resultado_d;
    logic                 estouro_q, estouro_d;
    logic                 aceita;
    logic [LARGURA-1:0]   res_comb, soma, dif;
    logic                 ovf_comb;
    logic [SW-1:0]        desloc;

    assign aceita = (estado_q == OCIOSO) && bus.valido_entrada;

`ifdef ULA_MUL_EN
    logic                 inicia_mul;
    logic                 fim_mul;
    logic [2*LARGURA-1:0] produto;

    assign inicia_mul = aceita && (bus.sinal_ula == ULA_MUL);

    ula_multiplicador #(.LARGURA(LARGURA)) u_mult (
        .clock     (clock),
        .reset     (reset),
        .inicio_i  (inicia_mul),
        .a_i       (bus.entrada1),
        .b_i       (bus.entrada2),
        .fim_o     (fim_mul),
        .produto_o (produto)
    );
`endif

    // Single-cycle operations evaluated straight from the bus at acceptance
    always_comb begin
        soma     = bus.entrada1 + bus.entrada2;
        dif      = bus.entrada1 - bus.entrada2;
        desloc   = bus.entrada2[SW-1:0];
        res_comb = '0;
        ovf_comb = 1'b0;
        case (bus.sinal_ula)
            ULA_AND: res_comb = bus.entrada1 & bus.entrada2;
            ULA_OR:  res_comb = bus.entrada1 | bus.entrada2;
            ULA_ADD: begin
                res_comb = soma;
                ovf_comb = (bus.entrada1[M] == bus.entrada2[M]) && (soma[M] != bus.entrada1[M]);
            end
            ULA_SUB: begin
                res_comb = dif;
                ovf_comb = (bus.entrada1[M] != bus.entrada2[M]) && (dif[M] != bus.entrada1[M]);
            end
            ULA_SLT: res_comb[0] = (bus.entrada1 < bus.entrada2);
            ULA_SLL: res_comb = bus.entrada1 << desloc;
            ULA_SRL: res_comb = bus.entrada1 >> desloc;
            default: res_comb = '0;
        endcase
    end

    // Next-state logic; RESULTADO never accepts, even with pronto_saida high
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            OCIOSO: begin
                if (bus.valido_entrada) begin
                    estado_d = RESULTADO;
`ifdef ULA_MUL_EN
                    if (bus.sinal_ula == ULA_MUL) begin
                        estado_d = EXECUTA;
                    end
`endif
                end
            end
            EXECUTA: begin
`ifdef ULA_MUL_EN
                if (fim_mul) begin
                    estado_d = RESULTADO;
                end
`else
                estado_d = OCIOSO;
`endif
            end
            RESULTADO: begin
                if (bus.pronto_saida) begin
                    estado_d = OCIOSO;
                end
            end
            default: estado_d = OCIOSO;
        endcase
    end

    // Result register loads on acceptance or when the multiplier finishes
    always_comb begin
        resultado_d = resultado_q;
        estouro_d   = estouro_q;
        if (aceita) begin
            resultado_d = res_comb;
            estouro_d   = ovf_comb;
        end
`ifdef ULA_MUL_EN
        if ((estado_q == EXECUTA) && fim_mul) begin
            resultado_d = produto[LARGURA-1:0];
            estouro_d   = |produto[2*LARGURA-1:LARGURA];
        end
`endif
    end

    // State and result registers
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q    <= OCIOSO;
            resultado_q <= '0;
            estouro_q   <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            resultado_q <= resultado_d;
            estouro_q   <= estouro_d;
        end
    end

    // Outputs decoded from the registered state and result
    always_comb begin
        bus.pronto_entrada = (estado_q == OCIOSO);
        bus.valido_saida   = (estado_q == RESULTADO);
        bus.saida_ula      = resultado_q;
        bus.zero           = (resultado_q == '0);
        bus.estouro        = estouro_q;
    end

endmodule

// File: tb/tb_ula_multiciclo.sv
// Self-checking bench for ula_multiciclo (LARGURA=8); honours ULA_MUL_EN.
module tb_ula_multiciclo;

    localparam int W = 8;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    ula_multiciclo_if #(.LARGURA(W)) bus ();

    ula_multiciclo #(.LARGURA(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         ovf;
    } vetor_t;

    typedef struct {
        logic [W-1:0] res;
        logic         z;
        logic         ovf;
        int           lat;
    } esperado_t;

    esperado_t fila[$];
    vetor_t    tabela[15];
    int checks = 0;
    int errors = 0;

    task automatic check(input string nome, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nome, got, exp);
        end
    endtask

    function automatic int lat_de(input logic [2:0] op);
`ifdef ULA_MUL_EN
        if (op == 3'b101) return W + 1;
`endif
        return 1;
    endfunction

    // Reference model written with plain integer arithmetic
    function automatic esperado_t modelo(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        esperado_t e;
        int ua, ub, sa, sb, r;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        e.ovf = 1'b0;
        e.res = '0;
        case (op)
            3'b000: e.res = a & b;
            3'b001: e.res = a | b;
            3'b010: begin r = sa + sb; e.res = W'(ua + ub); e.ovf = (r > 2**(W-1) - 1) || (r < -(2**(W-1))); end
            3'b011: begin r = sa - sb; e.res = W'(ua - ub); e.ovf = (r > 2**(W-1) - 1) || (r < -(2**(W-1))); end
            3'b100: e.res = (ua < ub) ? W'(1) : W'(0);
            3'b101: begin
`ifdef ULA_MUL_EN
                r = ua * ub; e.res = W'(r); e.ovf = (r >= 2**W);
`endif
            end
            3'b110: e.res = W'(ua << (ub % W));
            default: e.res = W'(ua >> (ub % W));
        endcase
        e.z   = (e.res == '0);
        e.lat = lat_de(op);
        return e;
    endfunction

    // Drive one operation, push its expectation, then pop and compare on valido_saida
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] res, input logic ovf);
        esperado_t e, got;
        int t, n;
        logic ocupado_ok;
        @(negedge clock);
        t = 0;
        while (!bus.pronto_entrada && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (t == 50) begin
            check("espera_pronto_entrada", 32'd0, 32'd1);
            return;
        end
        bus.valido_entrada = 1'b1;
        bus.sinal_ula      = op;
        bus.entrada1       = a;
        bus.entrada2       = b;
        e.res = res;
        e.z   = (res == '0);
        e.ovf = ovf;
        e.lat = lat_de(op);
        fila.push_back(e);
        @(posedge clock);
        #1;
        bus.valido_entrada = 1'b0;
        bus.entrada1       = W'($urandom);
        bus.entrada2       = W'($urandom);
        bus.sinal_ula      = 3'($urandom);
        n = 0;
        ocupado_ok = 1'b1;
        do begin
            @(negedge clock);
            n++;
            if (!bus.valido_saida && bus.pronto_entrada) ocupado_ok = 1'b0;
        end while (!bus.valido_saida && n < 200);
        got = fila.pop_front();
        check("latencia", n, got.lat);
        check("pronto_entrada_ocupado", {31'd0, ocupado_ok}, 32'd1);
        check("pronto_entrada_resultado", {31'd0, bus.pronto_entrada}, 32'd0);
        check("saida_ula", {24'd0, bus.saida_ula}, {24'd0, got.res});
        check("zero", {31'd0, bus.zero}, {31'd0, got.z});
        check("estouro", {31'd0, bus.estouro}, {31'd0, got.ovf});
        $display("op=%0d a=%h b=%h -> saida=%h zero=%b estouro=%b lat=%0d",
                 op, a, b, bus.saida_ula, bus.zero, bus.estouro, n);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pronto_entrada"}, {31'd0, bus.pronto_entrada}, 32'd1);
        check({tag, "_valido_saida"}, {31'd0, bus.valido_saida}, 32'd0);
        check({tag, "_saida_ula"}, {24'd0, bus.saida_ula}, 32'd0);
        check({tag, "_zero"}, {31'd0, bus.zero}, 32'd1);
        check({tag, "_estouro"}, {31'd0, bus.estouro}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        esperado_t m;
        logic [2:0] op;
        logic [W-1:0] a, b;

        tabela[0]  = '{3'b010, 8'h7F, 8'h01, 8'h80, 1'b1};
        tabela[1]  = '{3'b011, 8'h05, 8'h05, 8'h00, 1'b0};
        tabela[2]  = '{3'b100, 8'h03, 8'hF0, 8'h01, 1'b0};
        tabela[3]  = '{3'b100, 8'hF0, 8'h03, 8'h00, 1'b0};
        tabela[4]  = '{3'b110, 8'h81, 8'h09, 8'h02, 1'b0};
        tabela[5]  = '{3'b111, 8'h81, 8'h03, 8'h10, 1'b0};
        tabela[6]  = '{3'b000, 8'hF0, 8'h3C, 8'h30, 1'b0};
        tabela[7]  = '{3'b001, 8'hF0, 8'h0F, 8'hFF, 1'b0};
        tabela[8]  = '{3'b010, 8'hFF, 8'h01, 8'h00, 1'b0};
        tabela[9]  = '{3'b011, 8'h80, 8'h01, 8'h7F, 1'b1};
        tabela[10] = '{3'b010, 8'h80, 8'h80, 8'h00, 1'b1};
        tabela[11] = '{3'b011, 8'h7F, 8'hFF, 8'h80, 1'b1};
`ifdef ULA_MUL_EN
        tabela[12] = '{3'b101, 8'h10, 8'h11, 8'h10, 1'b1};
        tabela[13] = '{3'b101, 8'h0F, 8'h0F, 8'hE1, 1'b0};
`else
        tabela[12] = '{3'b101, 8'h10, 8'h11, 8'h00, 1'b0};
        tabela[13] = '{3'b101, 8'h0F, 8'h0F, 8'h00, 1'b0};
`endif
        tabela[14] = '{3'b111, 8'h80, 8'h0F, 8'h01, 1'b0};

        reset              = 1'b1;
        bus.valido_entrada = 1'b0;
        bus.entrada1       = '0;
        bus.entrada2       = '0;
        bus.sinal_ula      = '0;
        bus.pronto_saida   = 1'b1;
        repeat (2) @(negedge clock);
        check_reset_vals("reset");
        reset = 1'b0;

        // Directed vector table
        for (int i = 0; i < 15; i++) begin
            run_op(tabela[i].op, tabela[i].a, tabela[i].b, tabela[i].res, tabela[i].ovf);
        end

        // Random operations against the integer model
        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom);
            a  = W'($urandom);
            b  = W'($urandom);
            m  = modelo(op, a, b);
            run_op(op, a, b, m.res, m.ovf);
        end

        // Backpressure: result held, pending op waits for the release
        @(negedge clock);
        bus.pronto_saida   = 1'b0;
        bus.valido_entrada = 1'b1;
        bus.sinal_ula      = 3'b010;
        bus.entrada1       = 8'h01;
        bus.entrada2       = 8'h02;
        @(posedge clock);
        #1;
        bus.sinal_ula = 3'b011;
        bus.entrada1  = 8'h09;
        bus.entrada2  = 8'h04;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("bp_valido_saida", {31'd0, bus.valido_saida}, 32'd1);
            check("bp_saida_ula", {24'd0, bus.saida_ula}, 32'h03);
            check("bp_pronto_entrada", {31'd0, bus.pronto_entrada}, 32'd0);
        end
        bus.pronto_saida = 1'b1;
        @(negedge clock);
        check("bp_liberado_pronto", {31'd0, bus.pronto_entrada}, 32'd1);
        check("bp_liberado_valido", {31'd0, bus.valido_saida}, 32'd0);
        @(posedge clock);
        #1;
        bus.valido_entrada = 1'b0;
        @(negedge clock);
        check("bp_pendente_valido", {31'd0, bus.valido_saida}, 32'd1);
        check("bp_pendente_saida", {24'd0, bus.saida_ula}, 32'h05);
        $display("backpressure sequence: pending sub result=%h", bus.saida_ula);

        // Reset during the fourth cycle of a multiply
        @(negedge clock);
        bus.valido_entrada = 1'b1;
        bus.sinal_ula      = 3'b101;
        bus.entrada1       = 8'h10;
        bus.entrada2       = 8'h11;
        @(posedge clock);
        #1;
        bus.valido_entrada = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_reset_vals("reset_mul");
        reset = 1'b0;
        $display("reset mid-multiply: saida=%h valido=%b", bus.saida_ula, bus.valido_saida);
        run_op(3'b010, 8'h7F, 8'h01, 8'h80, 1'b1);

        check("fila_vazia", fila.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
